exp_module: RTL
===============

EXP_MODULE -- requirements
Module: exp_module

Interface
REQ-001 The block SHALL have one parameter: LOG2E_Q4, default 23, the log2(e) multiplier in U1Q4 (23/16 = 1.4375).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  input sample present.
REQ-005 in_ready  output  1  block accepts the input sample this cycle.
REQ-006 in_y_U3Q10  input  13  unsigned log-domain operand, 3 integer and 10 fraction bits.
REQ-007 out_valid  output  1  result present.
REQ-008 out_ready  input  1  downstream accepts the result this cycle.
REQ-009 out_x_U8Q8  output  16  unsigned result approximating e^y, 8 integer and 8 fraction bits.
REQ-010 out_sat  output  1  result saturated; qualified by out_valid.

Function
REQ-011 Transfer rule: an input transfer occurs on a cycle with in_valid=1 and in_ready=1; an output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-012 Pipeline: three registered stages, S1 (capture y), S2 (t = y*LOG2E_Q4), S3 (shift/saturate), each with its own valid bit.
REQ-013 Stage advance rule: a stage SHALL load when it is empty or when its downstream neighbour loads. S3 counts as downstream-loaded when out_ready=1.
REQ-014 in_ready SHALL equal the S1 load condition, computed combinationally from stage valids and out_ready.
REQ-015 Latency and throughput: with out_ready held at 1, a sample accepted in cycle n SHALL appear with out_valid=1 in cycle n+3; throughput SHALL be one sample per cycle.
REQ-016 Stall behaviour: while out_valid=1 and out_ready=0, out_x_U8Q8 and out_sat SHALL hold stable. No sample SHALL be dropped, duplicated or reordered.
REQ-017 Multiply width: t SHALL be the 18-bit unsigned product y*LOG2E_Q4, in U4Q14.
REQ-018 Field split: w = t[17:14]; mantissa m = {1, t[13:6]}, a 9-bit value in U1Q8 (linear 2^f ~ 1+f).
REQ-019 Result for w<=7: out_x_U8Q8 = m << w, zero-extended to 16 bits, with out_sat=0.
REQ-020 Result for w>=8: out_x_U8Q8 = 16'hFFFF and out_sat=1.
REQ-021 Simultaneous events: an input transfer and an output transfer in the same cycle SHALL both complete.
REQ-022 Stall propagation: a full pipeline with out_ready=0 SHALL drive in_ready=0.

Reset
REQ-023 While rst=1 at a clock edge, all stage valids SHALL clear. After that edge, out_valid=0, out_x_U8Q8=16'h0000 and out_sat=0.
REQ-024 Reset mid-operation SHALL discard all in-flight samples. in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-025 Macro EXP_ROUND_EN defined: t SHALL be replaced by t+32 (18 bits, no overflow possible) before the field split, rounding the mantissa to nearest. The saturation test SHALL use the rounded value.
REQ-026 Macro EXP_ROUND_EN undefined: the mantissa SHALL be truncated. All Verification values assume undefined.

Structure
REQ-027 Shared package softmax_pkg SHALL hold the following constants: Y_W=13, X_W=16, T_W=18, FRAC_SHIFT=6, W_SAT=8, LOG2E_Q4_DEFAULT=23.
REQ-028 Sub-module exp_pipe_stage (valid/ready register slice, data width parameterised) SHALL be instantiated three times. All arithmetic SHALL stay in exp_module.

Verification
REQ-029 y=0 -> out_x_U8Q8=16'h0100, out_sat=0, out_valid exactly 3 cycles after acceptance.
REQ-030 y=1024 (1.0) -> t=23552, w=1, m=368 -> out_x_U8Q8=16'h02E0 (2.875), out_sat=0.
REQ-031 y=5698 -> out_x_U8Q8=16'hFF80, out_sat=0; y=5699 -> 16'hFFFF, out_sat=1; y=8191 -> 16'hFFFF, out_sat=1.
REQ-032 Back-to-back stream of 10 values with out_ready=1 -> 10 results in order on consecutive cycles.
REQ-033 Random out_ready (50%) with continuous input -> output sequence equals the reference-model sequence, no loss or duplication. Outputs stable while stalled. in_ready=0 whenever all three stages are full and out_ready=0.
REQ-034 Three samples in flight, then rst=1 for one cycle -> out_valid=0 on the following cycle, no stale sample emitted, in_ready=1.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared widths and constants for the exp pipeline
package softmax_pkg;
    localparam int Y_W              = 13;
    localparam int X_W              = 16;
    localparam int T_W              = 18;
    localparam int FRAC_SHIFT       = 6;
    localparam int W_SAT            = 8;
    localparam int LOG2E_Q4_DEFAULT = 23;
endpackage

// File: rtl/exp_pipe_stage.sv
// exp_pipe_stage: one valid/ready register slice; loads when empty or when downstream loads
module exp_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         down_load,
    output logic         load,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    assign load      = !valid_q || down_load;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Take the upstream sample when the slot frees up; data holds while stalled or on bubbles
    always_comb begin
        valid_d = load ? in_valid : valid_q;
        data_d  = (load && in_valid) ? in_data : data_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/exp_module.sv
// exp_module: 3-stage e^y approximation (U3Q10 -> U8Q8) via 2^(y*log2e); EXP_ROUND_EN rounds the mantissa
module exp_module
    import softmax_pkg::*;
#(
    parameter int LOG2E_Q4 = LOG2E_Q4_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Y_W-1:0] in_y_U3Q10,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] out_x_U8Q8,
    output logic           out_sat
);
    localparam int H_W = T_W - FRAC_SHIFT;
`ifdef EXP_ROUND_EN
    localparam logic [T_W-1:0] RND = T_W'(1 << (FRAC_SHIFT - 1));
`else
    localparam logic [T_W-1:0] RND = '0;
`endif

    logic           s1_load, s2_load, s3_load;
    logic           s1_v, s2_v;
    logic [Y_W-1:0] s1_y;
    logic [H_W-1:0] t_hi, s2_t;
    logic [3:0]     w;
    logic [8:0]     m;
    logic [X_W:0]   r, s3_r;

    assign in_ready   = s1_load;
    assign out_x_U8Q8 = s3_r[X_W-1:0];
    assign out_sat    = s3_r[X_W];

    // Product in U4Q14 (optionally rounded), keeping only the exponent and mantissa bits
    always_comb begin
        t_hi = H_W'((T_W'(s1_y) * T_W'(LOG2E_Q4) + RND) >> FRAC_SHIFT);
    end

    // Split into integer exponent and linear mantissa, then shift or saturate
    always_comb begin
        w = s2_t[H_W-1 -: 4];
        m = {1'b1, s2_t[7:0]};
        r = (w >= 4'(W_SAT)) ? {1'b1, {X_W{1'b1}}} : {1'b0, X_W'(m) << w};
    end

    exp_pipe_stage #(.W(Y_W)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_y_U3Q10),
        .down_load(s2_load), .load(s1_load), .out_valid(s1_v), .out_data(s1_y)
    );

    exp_pipe_stage #(.W(H_W)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(s1_v), .in_data(t_hi),
        .down_load(s3_load), .load(s2_load), .out_valid(s2_v), .out_data(s2_t)
    );

    exp_pipe_stage #(.W(X_W + 1)) u_s3 (
        .clk(clk), .rst(rst), .in_valid(s2_v), .in_data(r),
        .down_load(out_ready), .load(s3_load), .out_valid(out_valid), .out_data(s3_r)
    );
endmodule
